// File: rtl/rr_arbiter_weighted_if.sv
// Request/grant bundle between N request sources, the arbiter and the shared sink.
// Latency: none, wires only.
// Backpressure: the sink acknowledges one beat at a time through ack; there is no other stall path.
interface rr_arbiter_weighted_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic            ack;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;

    // Request sources and sink side.
    modport master (
        output req, last, weight, ack,
        input  grant, grant_valid, grant_id
    );

    // Arbiter side.
    modport slave (
        input  req, last, weight, ack,
        output grant, grant_valid, grant_id
    );
endinterface

// File: rtl/rr_arbiter_weighted.sv
// Weighted round-robin arbiter: holds a channel for up to weight[i] whole packets, then rotates.
// Latency: grant registered 1 cycle after req; at least one idle cycle between tenures.
// Backpressure: beats advance only on ack; a packet in progress locks the grant until ack&last.
module rr_arbiter_weighted #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input logic                  clk,
    input logic                  rst,
    rr_arbiter_weighted_if.slave bus
);
    localparam int IDW = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic [WW-1:0]  credit;
    logic           in_pkt;
    logic [N-1:0]   grant_reg;
    logic [IDW-1:0] grant_id_reg;

    logic           found;
    logic [IDW-1:0] sel;
    logic [N-1:0]   sel_onehot;
    logic [WW-1:0]  sel_weight;
    logic [WW-1:0]  entry_credit;
    logic           cur_req;
    logic           cur_last;
    logic           pkt_end;
    logic           release_now;
    logic [IDW-1:0] next_ptr;

    // First requester in rotating order starting at ptr, plus its tenure length.
    always_comb begin
        found      = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                sel   = IDW'((int'(ptr) + k) % N);
            end
        end
        sel_onehot[sel] = 1'b1;
        sel_weight      = bus.weight[int'(sel)*WW +: WW];
        // A zero weight would give an empty tenure; it is promoted to one packet.
        entry_credit    = (sel_weight == '0) ? WW'(1) : sel_weight;
    end

    // Tenure end detection for the channel currently holding the grant.
    always_comb begin
        cur_req     = bus.req[grant_id_reg];
        cur_last    = bus.last[grant_id_reg];
        pkt_end     = bus.ack & cur_last;
        // Either the final packet of the tenure completes, or the requester
        // walked away between packets with no beat being accepted.
        release_now = (pkt_end && (credit == WW'(1))) ||
                      (!cur_req && !in_pkt && !bus.ack);
        next_ptr    = (grant_id_reg == IDW'(N-1)) ? '0 : grant_id_reg + IDW'(1);
    end

    // Grant FSM: IDLE picks a winner, GRANT counts packets until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            ptr          <= '0;
            credit       <= '0;
            in_pkt       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_reg    <= sel_onehot;
                        grant_id_reg <= sel;
                        credit       <= entry_credit;
                        in_pkt       <= 1'b0;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        ptr          <= next_ptr;
                        credit       <= '0;
                        in_pkt       <= 1'b0;
                        state        <= IDLE;
                    end else if (bus.ack) begin
                        if (cur_last) begin
                            in_pkt <= 1'b0;
                            credit <= credit - WW'(1);
                        end else begin
                            in_pkt <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.grant_valid = |grant_reg;
    assign bus.grant_id    = grant_id_reg;
endmodule
